// File: rtl/display_pkg.sv
// Shared types and constants for the LED panel bit-plane driver.
package display_pkg;

   typedef enum logic [2:0] {IDLE, SHIFT, DRAIN, BLANK, LATCH, SHOW} state_t;

   localparam int PIXEL_BITS = 24;
   localparam int R_OFF      = 16;
   localparam int G_OFF      = 8;
   localparam int B_OFF      = 0;

   // rgb lane c within a segment: 0=R, 1=G, 2=B
   function automatic int ch_off(input int c);
      case (c)
         0:       return R_OFF;
         1:       return G_OFF;
         default: return B_OFF;
      endcase
   endfunction

endpackage

// File: rtl/display_bcm_timer.sv
// Loadable down-counter that times the SHOW window of one bit plane.
module display_bcm_timer #(
   parameter int width = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [width-1:0] load_val,
   input  logic             dec,
   output logic             done
);

   logic [width-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && count != '0)
         count <= count - width'(1);
   end

   assign done = (count == '0);

endmodule

// File: rtl/display_bitplane_driver.sv
// HUB75-style panel scanner: shifts one bit plane per row, latches it and
// shows it for a binary-weighted time (BCM).
module display_bitplane_driver
   import display_pkg::*;
#(
   parameter int segments      = 2,
   parameter int columns       = 64,
   parameter int rows          = 16,
   parameter int bits          = 8,
   parameter int pixel_latency = 2,
   parameter int show_base     = 4
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    enable,
   output logic [$clog2(rows)+$clog2(columns)-1:0] addr,
   input  logic [PIXEL_BITS*segments-1:0]          cpixel,
   output logic [3*segments-1:0]                   rgb,
   output logic                                    pclk,
   output logic                                    latch,
   output logic                                    oe_n,
   output logic [$clog2(rows)-1:0]                 row,
   output logic                                    frame_done
);

   localparam int RW     = $clog2(rows);
   localparam int CW     = $clog2(columns);
   localparam int PW     = (bits > 1) ? $clog2(bits) : 1;
   localparam int TW     = $clog2((show_base << (bits-1)) + 1);
   localparam int STAGES = pixel_latency + 1;

   state_t          state, nxt_state;
   logic [RW-1:0]   cur_row;
   logic [CW-1:0]   col;
   logic [PW-1:0]   plane;
   logic            phase;
   logic [STAGES:0] vld_pipe;
   logic            issue, tag, timer_done;
   logic [TW-1:0]   show_len;
   logic [3*segments-1:0] rgb_nxt;

   assign issue    = (state == SHIFT) && !phase;
   assign tag      = vld_pipe[pixel_latency];
   assign show_len = TW'(show_base) << plane;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      latch     = 1'b0;
      oe_n      = 1'b1;
      case (state)
         IDLE:  if (enable) nxt_state = SHIFT;
         SHIFT: if (issue && col == CW'(columns-1)) nxt_state = DRAIN;
         // every tagged pixel clocked out and pclk back low
         DRAIN: if (vld_pipe == '0 && !pclk) nxt_state = BLANK;
         BLANK: nxt_state = LATCH;
         LATCH: begin
            latch     = 1'b1;
            nxt_state = SHOW;
         end
         SHOW: begin
            oe_n = 1'b0;
            if (timer_done) nxt_state = enable ? SHIFT : IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   display_bcm_timer #(.width(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == LATCH),
      .load_val (show_len - TW'(1)),
      .dec      (state == SHOW),
      .done     (timer_done)
   );

   for (genvar s = 0; s < segments; s++) begin : g_seg
      for (genvar c = 0; c < 3; c++) begin : g_ch
         localparam int OFF = PIXEL_BITS*s + ch_off(c);
         logic [7:0] ch_byte;
         assign ch_byte          = cpixel[OFF +: 8];
         assign rgb_nxt[3*s + c] = ch_byte[plane];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr       <= '0;
         rgb        <= '0;
         pclk       <= 1'b0;
         row        <= '0;
         frame_done <= 1'b0;
         cur_row    <= '0;
         col        <= '0;
         plane      <= '0;
         phase      <= 1'b0;
         vld_pipe   <= '0;
      end else begin
         frame_done <= 1'b0;
         vld_pipe   <= {vld_pipe[STAGES-1:0], issue};
         phase      <= (state == SHIFT) ? ~phase : 1'b0;
         // pclk rises the cycle after rgb is loaded, so data is set up at the edge
         pclk       <= vld_pipe[STAGES];
         if (issue) begin
            addr <= {cur_row, col};
            col  <= col + CW'(1);
         end
         if (tag) rgb <= rgb_nxt;
         if (state == BLANK) row <= cur_row;
         if (state == SHOW && timer_done) begin
            if (plane == PW'(bits-1)) begin
               plane   <= '0;
               cur_row <= cur_row + RW'(1);
               if (cur_row == RW'(rows-1)) frame_done <= 1'b1;
            end else begin
               plane <= plane + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_display_bitplane_driver.sv
// Directed bench for display_bitplane_driver on a 4-column, 2-row panel.
module tb_display_bitplane_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [2:0]  addr;
   logic [47:0] cpixel;
   logic [5:0]  rgb;
   logic        pclk, latch, oe_n, frame_done;
   logic [0:0]  row;

   int checks = 0;
   int errors = 0;
   int mode   = 0;

   display_bitplane_driver #(
      .segments(2), .columns(4), .rows(2), .bits(8),
      .pixel_latency(2), .show_base(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .addr(addr), .cpixel(cpixel),
      .rgb(rgb), .pclk(pclk), .latch(latch), .oe_n(oe_n), .row(row),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // framebuffer + encoder model: data for an address appears two cycles later
   logic [1:0] a_d1, a_d2;
   always @(posedge clk) begin
      a_d1 <= addr[1:0];
      a_d2 <= a_d1;
   end

   always_comb begin
      case (mode)
         0:       cpixel = {24'h000000, 24'hffffff};
         1:       cpixel = {24'hffffff, 24'hff00ff};
         2:       cpixel = {24'h000000, 24'h000001};
         3:       cpixel = {24'h000000, 6'b0, a_d2, 16'h0000};
         default: cpixel = '0;
      endcase
   end

   // panel-side observer
   logic       prev_pclk = 1'b0, prev_oe = 1'b1;
   logic [5:0] prev_rgb = '0;
   logic [0:0] prev_row = '0;
   logic [5:0] rise_rgb [0:7];
   logic [5:0] lat_rgb  [0:7];
   int rise_cnt = 0, lat_rises = 0, latch_cnt = 0;
   int oe_cnt = 0, show_len = 0, show_cnt = 0, fd_cnt = 0;
   int rgb_bad = 0, row_bad = 0;

   always @(negedge clk) begin
      prev_pclk <= pclk;
      prev_oe   <= oe_n;
      prev_rgb  <= rgb;
      prev_row  <= row;
      if (pclk && !prev_pclk) begin
         if (rise_cnt < 8) rise_rgb[rise_cnt] <= rgb;
         rise_cnt <= rise_cnt + 1;
      end
      if (pclk && rgb !== prev_rgb) rgb_bad <= rgb_bad + 1;
      if (row !== prev_row && (!oe_n || !prev_oe)) row_bad <= row_bad + 1;
      if (latch) begin
         lat_rises <= rise_cnt;
         lat_rgb   <= rise_rgb;
         rise_cnt  <= 0;
         latch_cnt <= latch_cnt + 1;
      end
      if (!oe_n) oe_cnt <= oe_cnt + 1;
      else if (!prev_oe) begin
         show_len <= oe_cnt;
         oe_cnt   <= 0;
         show_cnt <= show_cnt + 1;
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_show(input int budget);
      int target = show_cnt + 1;
      int n = 0;
      while (show_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("show_timeout", 32'(show_cnt >= target), 32'd1);
   endtask

   task automatic plane_step(input string tag, input int len,
                             input logic [5:0] e0, input logic [5:0] e1,
                             input logic [5:0] e2, input logic [5:0] e3,
                             input int nmode);
      wait_show(2000);
      mode = nmode;
      chk({tag, "_oe_cycles"}, show_len, len);
      chk({tag, "_pclk_rises"}, lat_rises, 32'd4);
      chk({tag, "_rgb0"}, 32'(lat_rgb[0]), 32'(e0));
      chk({tag, "_rgb1"}, 32'(lat_rgb[1]), 32'(e1));
      chk({tag, "_rgb2"}, 32'(lat_rgb[2]), 32'(e2));
      chk({tag, "_rgb3"}, 32'(lat_rgb[3]), 32'(e3));
   endtask

   initial begin
      int lc, sc;
      logic [2:0] a_hold;
      rst_n  = 1'b0;
      enable = 1'b1;
      mode   = 0;
      repeat (3) @(negedge clk);
      chk("rst_oe_n", 32'(oe_n), 32'd1);
      chk("rst_latch", 32'(latch), 32'd0);
      chk("rst_pclk", 32'(pclk), 32'd0);
      chk("rst_rgb", 32'(rgb), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_row", 32'(row), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);

      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("second_addr", 32'(addr), 32'd1);

      // frame 1, row 0: seg0 white, seg1 black on every plane
      for (int p = 0; p < 8; p++)
         plane_step($sformatf("r0p%0d", p), 4 << p,
                    6'b000111, 6'b000111, 6'b000111, 6'b000111, (p == 7) ? 2 : 0);
      chk("row_after_r0", 32'(row), 32'd0);

      // frame 1, row 1: only blue bit 0 of seg0, then channel mapping
      plane_step("r1p0", 4, 6'b000100, 6'b000100, 6'b000100, 6'b000100, 2);
      chk("row_in_r1", 32'(row), 32'd1);
      plane_step("r1p1", 8, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 1);
      for (int p = 2; p < 7; p++)
         plane_step($sformatf("r1p%0d", p), 4 << p,
                    6'b111101, 6'b111101, 6'b111101, 6'b111101, 1);
      chk("no_early_frame_done", 32'(fd_cnt), 32'd0);
      plane_step("r1p7", 512, 6'b111101, 6'b111101, 6'b111101, 6'b111101, 3);
      chk("frame_done_once", 32'(fd_cnt), 32'd1);
      chk("wrap_addr_row", 32'(addr[2]), 32'd0);

      // frame 2, row 0: red of seg0 follows column number
      plane_step("f2p0", 4, 6'b000000, 6'b000001, 6'b000000, 6'b000001, 3);
      plane_step("f2p1", 8, 6'b000000, 6'b000000, 6'b000001, 6'b000001, 0);
      plane_step("f2p2", 16, 6'b000111, 6'b000111, 6'b000111, 6'b000111, 0);

      // stop request during plane 3 shift: plane still completes in full
      enable = 1'b0;
      plane_step("stop_p3", 32, 6'b000111, 6'b000111, 6'b000111, 6'b000111, 0);
      lc = latch_cnt;
      sc = show_cnt;
      a_hold = addr;
      repeat (40) @(negedge clk);
      chk("idle_no_latch", latch_cnt, lc);
      chk("idle_no_show", show_cnt, sc);
      chk("idle_oe_n", 32'(oe_n), 32'd1);
      chk("idle_addr", 32'(addr), 32'(a_hold));
      chk("idle_pclk", 32'(pclk), 32'd0);

      // restart, then pull reset in the middle of SHOW
      enable = 1'b1;
      begin
         int n = 0;
         while (oe_n !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
         end
         chk("show_start_timeout", 32'(n < 500), 32'd1);
      end
      @(negedge clk);
      chk("in_show_oe_n", 32'(oe_n), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_oe_n", 32'(oe_n), 32'd1);
      chk("async_rst_latch", 32'(latch), 32'd0);
      chk("async_rst_rgb", 32'(rgb), 32'd0);
      chk("async_rst_addr", 32'(addr), 32'd0);
      chk("async_rst_row", 32'(row), 32'd0);

      chk("rgb_stable_at_pclk", rgb_bad, 32'd0);
      chk("row_change_blanked", row_bad, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
